// File: rtl/add8_share_ctrl.sv
// -----------------------------------------------------------------------------
// add8_share_ctrl
//   Arbitrates NREQ requesters onto a single shared 8-bit ripple-carry adder
//   (add8, gate-level, no carry-in) and sequences add / subtract operations
//   through it. Subtract takes two passes: a negate pass (~B + 1), then an
//   add pass. Results leave through a registered valid/ready channel.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   req_valid  [NREQ]    request pending, one bit per requester
//   req_ready  [NREQ]    one-hot accept pulse to the winning requester
//   req_a      [NREQ*W]  operand A, requester i at [i*W +: W]
//   req_b      [NREQ*W]  operand B, same packing
//   req_sub    [NREQ]    1 = A-B, 0 = A+B
//   rsp_valid            result valid
//   rsp_ready            consumer accepts result
//   rsp_id     [IDW]     index of the requester owning the result
//   rsp_sum    [W]       result modulo 2^W
//   rsp_cout             add: carry-out; sub: 1 when A >= B
//
// Build option
//   ADD8_SHARE_FIXED_PRIO_EN : lowest requesting index always wins; no
//   rotating pointer is kept.
// -----------------------------------------------------------------------------

// Gate-level 8-bit ripple-carry adder without carry-in.
module add8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [8:0] c;

    assign c[0] = 1'b0;

    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign sum_o[g]  = a_i[g] ^ b_i[g] ^ c[g];
        assign c[g+1]    = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
    end

    assign cout_o = c[8];
endmodule

module add8_share_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        ADD  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sub_q, sub_d;
    logic [IDW-1:0] id_q, id_d;
    logic           c1_q, c1_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
`ifndef ADD8_SHARE_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
`endif

    // Arbitration results
    logic           found;
    logic [IDW-1:0] win;
    logic [W-1:0]   win_a, win_b;
    logic           win_sub;

    // Shared adder
    logic [7:0]     add_a, add_b, add_sum;
    logic           add_cout;

    add8 u_add8 (
        .a_i    (add_a),
        .b_i    (add_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Winner search: first set bit upward from the base index, wrapping.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        found   = 1'b0;
        win     = '0;
        win_a   = '0;
        win_b   = '0;
        win_sub = 1'b0;
`ifdef ADD8_SHARE_FIXED_PRIO_EN
        base = 0;
`else
        base = 32'(rr_ptr_q);
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (base + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win     = IDW'(idx);
                win_a   = req_a[idx*W +: W];
                win_b   = req_b[idx*W +: W];
                win_sub = req_sub[idx];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        id_d        = id_q;
        c1_d        = c1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
`ifndef ADD8_SHARE_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        req_ready   = '0;
        add_a       = '0;
        add_b       = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    // No accept while reset is asserted: the capture would be
                    // thrown away and the requester would lose its request.
                    req_ready[win] = !rst;
                    a_d     = win_a;
                    b_d     = win_b;
                    sub_d   = win_sub;
                    id_d    = win;
                    state_d = win_sub ? NEG : ADD;
                end
            end
            NEG: begin
                add_a   = ~b_q;
                add_b   = 8'h01;
                b_d     = add_sum;
                c1_d    = add_cout;
                state_d = ADD;
            end
            ADD: begin
                add_a       = a_q;
                add_b       = b_q;
                rsp_sum_d   = add_sum;
                // Negating B=0 carries out; that carry means "no borrow".
                rsp_cout_d  = sub_q ? (c1_q | add_cout) : add_cout;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifndef ADD8_SHARE_FIXED_PRIO_EN
                    rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= '0;
            c1_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
`ifndef ADD8_SHARE_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            id_q        <= id_d;
            c1_q        <= c1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
`ifndef ADD8_SHARE_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_add8_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add8_share_ctrl
//   Scoreboard bench for add8_share_ctrl: every observed grant pushes the
//   expected result of the granted requester's operands; every response is
//   compared against the queue head while valid, and popped on handshake.
// -----------------------------------------------------------------------------
module tb_add8_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;

    logic [W-1:0] drv_a [NREQ];
    logic [W-1:0] drv_b [NREQ];
    logic         drv_sub [NREQ];

    typedef struct {
        int       id;
        logic [7:0] sum;
        logic     cout;
        logic     sub;
        int       acc;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic prev_rv = 1'b0;

    add8_share_ctrl #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = drv_a[i];
            req_b[i*W +: W] = drv_b[i];
            req_sub[i]      = drv_sub[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b,
                                   input logic s, input int acc);
        exp_t e;
        logic [8:0] full;
        e.id  = id;
        e.sub = s;
        e.acc = acc;
        if (s) begin
            e.sum  = a - b;
            e.cout = (a >= b);
        end else begin
            full   = {1'b0, a} + {1'b0, b};
            e.sum  = full[7:0];
            e.cout = full[8];
        end
        return e;
    endfunction

    // Sampled on the falling edge, well away from the active edge.
    task automatic monitor();
        int g;
        cyc++;
        if (rst) begin
            prev_rv = 1'b0;
            return;
        end
        if (req_ready != '0) begin
            check("grant_onehot", $countones(req_ready), 1);
            check("grant_to_valid", req_ready & ~req_valid, 0);
            g = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            grants.push_back(g);
            sb.push_back(model(g, drv_a[g], drv_b[g], drv_sub[g], cyc));
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                if (!prev_rv)
                    check("latency", cyc - sb[0].acc, sb[0].sub ? 3 : 2);
                check("rsp_id", rsp_id, sb[0].id);
                check("rsp_sum", rsp_sum, sb[0].sum);
                check("rsp_cout", rsp_cout, sb[0].cout);
                check("no_grant_in_resp", req_ready, 0);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
        prev_rv = rsp_valid;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        int got;
        drv_a[i]     = a;
        drv_b[i]     = b;
        drv_sub[i]   = s;
        req_valid[i] = 1'b1;
        n = grants.size();
        for (int k = 0; k < 20 && grants.size() == n; k++) step();
        got = grants.size() - n;
        check("grant_seen", got, 1);
        if (got > 0) check("grant_id", grants[grants.size()-1], i);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() > 0; k++) step();
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"},    rsp_id, 0);
        check({tag, "_rsp_sum"},   rsp_sum, 0);
        check({tag, "_rsp_cout"},  rsp_cout, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic grab_grants(input int cnt, input int exp_order[4]);
        int n;
        n = grants.size();
        for (int k = 0; k < 60 && grants.size() < n + cnt; k++) step();
        req_valid = '0;
        check("rr_count", grants.size() - n, cnt);
        for (int k = 0; k < cnt && n + k < grants.size(); k++)
            check($sformatf("rr_order%0d", k), grants[n+k], exp_order[k]);
        drain();
    endtask

    initial begin
        int ord[4];
        int n;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            drv_a[i]   = '0;
            drv_b[i]   = '0;
            drv_sub[i] = 1'b0;
        end
        repeat (3) step();
        check_idle_zero("reset");
        rst = 1'b0;

        // Directed add / subtract cases
        issue(0, 8'h7F, 8'h01, 1'b0); drain();
        issue(1, 8'hFF, 8'h01, 1'b0); drain();
        issue(2, 8'h05, 8'h07, 1'b1); drain();
        issue(2, 8'h10, 8'h00, 1'b1); drain();
        issue(2, 8'h33, 8'h33, 1'b1); drain();
        issue(3, 8'hA5, 8'h5A, 1'b0); drain();

        // Round-robin with all requesters held, then only 0 and 2
        do_reset();
        drv_a[0] = 8'h10; drv_b[0] = 8'h01; drv_sub[0] = 1'b0;
        drv_a[1] = 8'h20; drv_b[1] = 8'h03; drv_sub[1] = 1'b1;
        drv_a[2] = 8'hF0; drv_b[2] = 8'h20; drv_sub[2] = 1'b0;
        drv_a[3] = 8'h01; drv_b[3] = 8'h02; drv_sub[3] = 1'b1;
        req_valid = 4'b1111;
`ifdef ADD8_SHARE_FIXED_PRIO_EN
        ord = '{0, 0, 0, 0};
`else
        ord = '{0, 1, 2, 3};
`endif
        grab_grants(4, ord);
        req_valid = 4'b0101;
`ifdef ADD8_SHARE_FIXED_PRIO_EN
        ord = '{0, 0, 0, 0};
`else
        ord = '{0, 2, 0, 2};
`endif
        grab_grants(4, ord);

        // Backpressure: hold rsp_ready low while another requester waits
        rsp_ready = 1'b0;
        issue(1, 8'h12, 8'h34, 1'b0);
        for (int k = 0; k < 10 && !rsp_valid; k++) step();
        check("bp_rsp_valid", rsp_valid, 1);
        req_valid[3] = 1'b1;
        drv_a[3] = 8'h80; drv_b[3] = 8'h80; drv_sub[3] = 1'b0;
        repeat (5) step();
        check("bp_sb_held", sb.size(), 1);
        rsp_ready = 1'b1;
        step();
        check("bp_released", sb.size(), 0);
        n = grants.size();
        step();
        check("bp_next_grant", grants.size() - n, 1);
        req_valid[3] = 1'b0;
        drain();

        // Reset during NEG of a subtract from req3
        issue(1, 8'h01, 8'h01, 1'b0); drain();
        issue(3, 8'h20, 8'h05, 1'b1);
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        check_idle_zero("midrst");
        repeat (4) step();
        // Pointer must restart at 0 even though req1 was served last
        req_valid = 4'b0101;
        n = grants.size();
        for (int k = 0; k < 10 && grants.size() == n; k++) step();
        req_valid = '0;
        check("midrst_ptr_grant", (grants.size() > n) ? grants[n] : 99, 0);
        drain();
        issue(3, 8'h20, 8'h05, 1'b1); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add8_share_ctrl.md
Name: add8_share_ctrl

Overview:
- Arbitrates NREQ requesters onto one shared 8-bit ripple-carry adder datapath and sequences each operation through it.
- Supports add and subtract. The adder has no carry-in, so subtract runs two passes: first a negate pass (~B + 1), then an add pass.
- Sits between the binary arithmetic clients and the single gate-level add8 instance, with a registered response channel.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width; fixed to the adder width (8)
- IDW, 2, requester id width; must equal clog2(NREQ)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  request pending, one bit per requester
- req_ready  output  NREQ  one-hot accept pulse to the winning requester
- req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W]
- req_b  input  NREQ*W  operand B; same packing as req_a
- req_sub  input  NREQ  1 = A-B, 0 = A+B
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_sum  output  W  result, modulo 2^W
- rsp_cout  output  1  add: carry-out; sub: 1 when A>=B (no borrow)

Behaviour:
- One clock; reset is synchronous, active-high: rst sampled high on a clk edge resets the block.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rr_ptr=0, state=IDLE.
- States: IDLE, NEG, ADD, RESP.
- IDLE:
  - If any req_valid is high, pick the winner by round-robin: the first set bit searching upward from rr_ptr, wrapping.
  - Drive req_ready[winner]=1 combinationally in this cycle only. The handshake completes in this cycle.
  - Latch A, B, sub and id into internal registers.
  - Next state is NEG if sub=1, otherwise ADD.
  - If no req_valid is high, req_ready=0 and the block stays in IDLE.
- NEG:
  - Adder inputs are (~B, 8'h01). Store the sum in the B register and the carry-out in c1.
  - Next state is ADD.
- ADD:
  - Adder inputs are (A, Breg).
  - Register rsp_sum = sum.
  - Register rsp_cout = cout for add, or c1 | cout for sub.
  - Set rsp_valid=1. Next state is RESP.
- RESP:
  - Hold rsp_valid, rsp_sum, rsp_cout and rsp_id stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid←0, rr_ptr←(id+1) mod NREQ, next state is IDLE.
  - No new request is accepted in RESP (no overlap).
- Latency from the accept edge to rsp_valid: add 2 cycles, sub 3 cycles.
- Peak throughput with rsp_ready held high: one add per 3 cycles, one sub per 4 cycles.
- Only the winner sees req_ready. Losers keep req_valid asserted; they are never dropped.
- Operands are sampled only in the accept cycle. Later changes on req_a/req_b have no effect on the operation in flight.
- The adder is combinational and is used in exactly one state per pass. Its inputs are muxed by state and tied to 0 in IDLE/RESP.
- Subtract boundary cases:
  - B=0: the NEG pass gives 0 with c1=1, so rsp_cout=1.
  - A=B: result 0, rsp_cout=1.
- Reset mid-operation (in NEG/ADD/RESP): abort, discard the result, return to IDLE with rr_ptr=0. No rsp_valid is issued for the aborted request; the requester re-issues it.
- A req_valid bit at an index >= NREQ does not exist. rr_ptr is always < NREQ.

Optional Feature:
- Macro: ADD8_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is not implemented and the winner ignores history. Everything else is unchanged.
- Undefined (default): round-robin as described above.

Test Plan:
- Add, rsp_ready held high: req0 A=0x7F, B=0x01, sub=0 -> req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_sum=0x80, rsp_cout=0, rsp_id=0.
- Add overflow: req1 A=0xFF, B=0x01 -> rsp_sum=0x00, rsp_cout=1, rsp_id=1.
- Subtract, checked at latency 3:
  - req2 A=0x05, B=0x07, sub=1 -> rsp_sum=0xFE, rsp_cout=0.
  - A=0x10, B=0x00 -> rsp_sum=0x10, rsp_cout=1.
  - A=0x33, B=0x33 -> rsp_sum=0x00, rsp_cout=1.
- Round-robin order: after reset, all 4 req_valid held -> grant order 0,1,2,3. Then only req0 and req2 held -> order 0,2,0,2.
  - With ADD8_SHARE_FIXED_PRIO_EN defined, the same stimulus gives 0,0,0,...
- Backpressure: rsp_ready low 5 cycles during RESP -> rsp_valid/rsp_sum/rsp_id stable and req_ready=0 throughout. Releasing rsp_ready completes the handshake in 1 cycle, then IDLE.
- Reset mid-op: assert rst during NEG of a sub from req3 -> next cycle state IDLE, all outputs 0, no rsp_valid. After release, req3 is re-granted first when it is the only requester.
